// File: rtl/i2c_disp_pkg.sv
// Shared types and constants for the I2C sample display: FSM encoding,
// active-low seven-segment glyphs (bit0=a .. bit6=g, bit7=dp).
package i2c_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    // Entry n is the glyph for nibble value n (listed F down to 0).
    localparam logic [15:0][7:0] SEG_GLYPH = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/i2c_sample_display_seg.sv
// Combinational nibble to active-low seven-segment pattern decoder.
module seg_hex_decode
    import i2c_disp_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [7:0] seg_o
);

    assign seg_o = SEG_GLYPH[nib_i];

endmodule

// File: rtl/i2c_sample_display.sv
// Captures I2C samples into a 4-digit multiplexed seven-segment display.
// Optional macro I2C_DISP_BCD_EN selects decimal display via double-dabble.
module i2c_sample_display
    import i2c_disp_pkg::*;
#(
    parameter int DIGIT_TICKS = 12500,
    parameter int BLANK_LZ    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sample,
    input  logic        sample_valid,
    input  logic        sample_err,
    output logic        busy,
    output logic        ovf,
    output logic [7:0]  segments,
    output logic [3:0]  digits
);

    localparam int TICK_W = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIGIT_TICKS - 1);

    logic [15:0] nib_q, nib_d;
    logic        err_q, err_d;
    logic        ovf_w;

`ifdef I2C_DISP_BCD_EN
    state_e      state_q, state_d;
    logic [35:0] sr_q, sr_d;
    logic [3:0]  it_q, it_d;
    logic        ovf_q, ovf_d;
    logic        pend_vld_q, pend_vld_d;
    logic [15:0] pend_smp_q, pend_smp_d;
    logic        pend_err_q, pend_err_d;
    logic        take;
    logic [15:0] src_smp;
    logic        src_err;

    function automatic logic [35:0] dabble_step(input logic [35:0] s);
        logic [35:0] t;
        t = s;
        for (int k = 0; k < 5; k++) begin
            if (t[16 + 4*k +: 4] >= 4'd5) begin
                t[16 + 4*k +: 4] = t[16 + 4*k +: 4] + 4'd3;
            end
        end
        return {t[34:0], 1'b0};
    endfunction

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        it_d       = it_q;
        nib_d      = nib_q;
        err_d      = err_q;
        ovf_d      = ovf_q;
        pend_vld_d = pend_vld_q;
        pend_smp_d = pend_smp_q;
        pend_err_d = pend_err_q;
        take       = 1'b0;
        src_smp    = sample;
        src_err    = sample_err;
        case (state_q)
            ST_IDLE: begin
                if (pend_vld_q) begin
                    take       = 1'b1;
                    src_smp    = pend_smp_q;
                    src_err    = pend_err_q;
                    // A strobe arriving now refills the slot just vacated.
                    pend_vld_d = sample_valid;
                    pend_smp_d = sample;
                    pend_err_d = sample_err;
                end else if (sample_valid) begin
                    take = 1'b1;
                end
                if (take) begin
                    if (src_err) begin
                        err_d = 1'b1;
                        ovf_d = 1'b0;
                    end else begin
                        sr_d    = {20'd0, src_smp};
                        it_d    = 4'd0;
                        state_d = ST_CONV;
                    end
                end
            end
            ST_CONV: begin
                sr_d = dabble_step(sr_q);
                it_d = it_q + 4'd1;
                if (it_q == 4'd15) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                nib_d   = sr_q[31:16];
                err_d   = 1'b0;
                ovf_d   = (sr_q[35:32] != 4'd0);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE && sample_valid) begin
            pend_vld_d = 1'b1;
            pend_smp_d = sample;
            pend_err_d = sample_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            it_q       <= 4'd0;
            ovf_q      <= 1'b0;
            pend_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            it_q       <= it_d;
            ovf_q      <= ovf_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        sr_q       <= sr_d;
        pend_smp_q <= pend_smp_d;
        pend_err_q <= pend_err_d;
    end

    assign busy  = (state_q != ST_IDLE);
    assign ovf_w = ovf_q;
`else
    always_comb begin
        nib_d = nib_q;
        err_d = err_q;
        if (sample_valid) begin
            if (sample_err) begin
                err_d = 1'b1;
            end else begin
                nib_d = sample;
                err_d = 1'b0;
            end
        end
    end

    assign busy  = 1'b0;
    assign ovf_w = 1'b0;
`endif

    assign ovf = ovf_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            nib_q <= 16'd0;
            err_q <= 1'b0;
        end else begin
            nib_q <= nib_d;
            err_q <= err_d;
        end
    end

    logic [TICK_W-1:0] tick_q, tick_d;
    logic [1:0]        scan_q, scan_d;
    logic [7:0]        seg_q;
    logic [7:0]        glyph;
    logic [7:0]        pat;
    logic [15:0]       upper;

    seg_hex_decode u_dec (
        .nib_i (nib_q[{scan_q, 2'b00} +: 4]),
        .seg_o (glyph)
    );

    // A digit is a leading zero when it and every more significant digit are 0.
    assign upper = nib_q >> {scan_q, 2'b00};

    always_comb begin
        pat = glyph;
        if (BLANK_LZ != 0 && scan_q != 2'd0 && upper == 16'd0 && !ovf_w) begin
            pat = SEG_BLANK;
        end
        if (ovf_w && scan_q == 2'd3) begin
            pat[7] = 1'b0;
        end
        if (err_q) begin
            pat = SEG_DASH;
        end
    end

    always_comb begin
        tick_d = tick_q + TICK_W'(1);
        scan_d = scan_q;
        if (tick_q == TICK_LAST) begin
            tick_d = '0;
            scan_d = scan_q + 2'd1;
        end
    end

    // Tick 0 of each digit is the blanking gap; the digit's pattern is latched there.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= '0;
            scan_q <= 2'd0;
            seg_q  <= SEG_BLANK;
        end else begin
            tick_q <= tick_d;
            scan_q <= scan_d;
            if (tick_q == '0) begin
                seg_q <= pat;
            end
        end
    end

    assign digits   = (tick_q == '0) ? 4'hF : ~(4'b0001 << scan_q);
    assign segments = (tick_q == '0) ? SEG_BLANK : seg_q;

endmodule

// File: tb/tb_i2c_sample_display.sv
// Directed plus randomized bench for i2c_sample_display (hex or BCD build).
`timescale 1ns/1ps
module tb_i2c_sample_display;

    localparam int T   = 4;
    localparam int BLZ = 0;
`ifdef I2C_DISP_BCD_EN
    localparam bit BCD = 1'b1;
`else
    localparam bit BCD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sample = 16'd0;
    logic        sample_valid = 1'b0;
    logic        sample_err = 1'b0;
    logic        busy, ovf;
    logic [7:0]  segments;
    logic [3:0]  digits;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    i2c_sample_display #(.DIGIT_TICKS(T), .BLANK_LZ(BLZ)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_err   (sample_err),
        .busy         (busy),
        .ovf          (ovf),
        .segments     (segments),
        .digits       (digits)
    );

    // Log of distinct patterns seen on digit 2, for the overwrite scenario.
    logic [7:0] d2_log[$];
    bit         mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en && digits == 4'b1011) begin
            if (d2_log.size() == 0 || d2_log[d2_log.size()-1] != segments)
                d2_log.push_back(segments);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] glyph(input int n);
        case (n)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90; 10: return 8'h88; 11: return 8'h83;
           12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; default: return 8'h8E;
        endcase
    endfunction

    function automatic int pow10(input int d);
        int r;
        r = 1;
        for (int k = 0; k < d; k++) r = r * 10;
        return r;
    endfunction

    // Expected pattern of digit d for committed value v (or error e).
    function automatic logic [7:0] exp_seg(input int v, input bit e, input int d);
        int digit, upper;
        bit ov;
        logic [7:0] g;
        if (e) return 8'hBF;
        ov = BCD && (v > 9999);
        if (BCD) begin
            upper = (v % 10000) / pow10(d);
            digit = upper % 10;
        end else begin
            upper = v >> (4 * d);
            digit = upper & 15;
        end
        g = glyph(digit);
        if (BLZ != 0 && d != 0 && upper == 0 && !ov) g = 8'hFF;
        if (ov && d == 3) g[7] = 1'b0;
        return g;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int c = 0; c < 60 && busy !== 1'b0; c++) step();
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic strobe(input int v, input bit e);
        sample       = v[15:0];
        sample_err   = e;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        sample_err   = 1'b0;
    endtask

    task automatic show_check(input int v, input bit e, input string tag);
        logic [3:0] want_d;
        logic [7:0] want_s;
        bit         got;
        repeat (4 * T + 2) step();
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, (BCD && !e && v > 9999)});
        for (int d = 0; d < 4; d++) begin
            want_d = ~(4'b0001 << d);
            got = 1'b0;
            for (int c = 0; c < 8 * T && !got; c++) begin
                if (digits === want_d) got = 1'b1;
                else step();
            end
            chk({tag, "_en"}, {31'd0, got}, 32'd1);
            want_s = exp_seg(v, e, d);
            chk($sformatf("%s_d%0d", tag, d), {24'd0, segments}, {24'd0, want_s});
        end
    endtask

    task automatic apply(input int v, input bit e, input string tag);
        strobe(v, e);
        wait_idle(tag);
        show_check(v, e, tag);
    endtask

    initial begin
        logic [3:0] ed;
        logic [7:0] es;
        int         v;
        bit         e;

        // Reset state and scan pattern after release.
        rst = 1'b1;
        repeat (3) step();
        chk("rst_digits", {28'd0, digits}, 32'hF);
        chk("rst_seg", {24'd0, segments}, 32'hFF);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            ed = ((k % T) == 0) ? 4'hF : ~(4'b0001 << ((k / T) % 4));
            es = ((k % T) == 0) ? 8'hFF : 8'hC0;
            chk($sformatf("scan_dig_k%0d", k), {28'd0, digits}, {28'd0, ed});
            chk($sformatf("scan_seg_k%0d", k), {24'd0, segments}, {24'd0, es});
            step();
        end

`ifdef I2C_DISP_BCD_EN
        // Decimal 1234: busy for 17 cycles, then display.
        strobe(1234, 1'b0);
        for (int c = 0; c < 17; c++) begin
            chk($sformatf("busy_hi_c%0d", c), {31'd0, busy}, 32'd1);
            step();
        end
        chk("busy_lo", {31'd0, busy}, 32'd0);
        show_check(1234, 1'b0, "bcd1234");
`else
        apply(16'h1234, 1'b0, "hex1234");
`endif
        apply(65535, 1'b0, "max");
        apply(7, 1'b0, "seven");
        apply(16'h0BEE, 1'b1, "err");
        apply(0, 1'b0, "zero");

        for (int r = 0; r < 8; r++) begin
            v = $urandom_range(0, 65535);
            e = ($urandom_range(0, 4) == 0);
            apply(v, e, $sformatf("rnd%0d", r));
        end

`ifdef I2C_DISP_BCD_EN
        // Three strobes back to back: middle one is overwritten in the pending slot.
        d2_log.delete();
        mon_en = 1'b1;
        sample = 16'd100; sample_valid = 1'b1; step();
        sample = 16'd200; step();
        sample = 16'd300; step();
        sample_valid = 1'b0;
        wait_idle("ovw100");
        step();
        chk("ovw_pending_busy", {31'd0, busy}, 32'd1);
        wait_idle("ovw300");
        show_check(300, 1'b0, "ovw300");
        mon_en = 1'b0;
        begin
            int p1, p3, bad2;
            p1 = -1; p3 = -1; bad2 = 0;
            foreach (d2_log[i]) begin
                if (p1 < 0 && d2_log[i] == glyph(1)) p1 = i;
                else if (p1 >= 0 && p3 < 0 && d2_log[i] == glyph(3)) p3 = i;
                if (p1 >= 0 && d2_log[i] == glyph(2)) bad2 = 1;
            end
            chk("ovw_saw100", {31'd0, (p1 >= 0)}, 32'd1);
            chk("ovw_saw300", {31'd0, (p3 > p1)}, 32'd1);
            chk("ovw_no200", bad2, 32'd0);
        end

        // Reset mid-conversion with a pending entry.
        strobe(5000, 1'b0);
        repeat (3) step();
        strobe(6000, 1'b0);
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_dig", {28'd0, digits}, 32'hF);
        chk("midrst_seg", {24'd0, segments}, 32'hFF);
        rst = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 20; c++) begin
                if (busy !== 1'b0) seen = 1'b1;
                step();
            end
            chk("midrst_pend_cleared", {31'd0, seen}, 32'd0);
        end
        show_check(0, 1'b0, "midrst_disp");
        apply(4321, 1'b0, "after_rst");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
